// File: rtl/anim_pkg.sv
// anim_pkg: shared constants for the animation datapath.
//   - command code width, sprite size, pixel coordinate widths
//   - FSM state encodings
//   - waypoint (node) coordinate lookup helpers
package anim_pkg;

  localparam int CODE_W = 3;
  localparam int SPRITE = 4;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_STEP_WAIT = 3'd1;
  localparam state_t ST_T_ERASE   = 3'd2;
  localparam state_t ST_T_MOVE    = 3'd3;
  localparam state_t ST_T_DRAW    = 3'd4;
  localparam state_t ST_T_WAIT    = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // Top-left corner of the coin sprite at each waypoint.
  function automatic logic [X_W-1:0] node_x(input logic [CODE_W-1:0] k);
    logic [X_W-1:0] r;
    case (k)
      3'd0:    r = 8'd8;
      3'd1:    r = 8'd40;
      3'd2:    r = 8'd72;
      3'd3:    r = 8'd104;
      3'd4:    r = 8'd136;
      3'd5:    r = 8'd136;
      3'd6:    r = 8'd72;
      default: r = 8'd8;
    endcase
    return r;
  endfunction

  function automatic logic [Y_W-1:0] node_y(input logic [CODE_W-1:0] k);
    logic [Y_W-1:0] r;
    case (k)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: r = 7'd56;
      default:                      r = 7'd24;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/anim_frame_ticker.sv
// anim_frame_ticker: free-running frame counter (0..DIV-1) with a one-cycle
// tick strobe in the cycle the counter wraps.
//   clock  - system clock
//   resetn - synchronous active-low reset (counter back to 0)
//   tick   - frame tick strobe
// Build option: ANIM_FAST_SIM_EN forces the divider to 4 cycles for
// simulation; otherwise FRAME_DIV is used.
module anim_frame_ticker #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);

`ifdef ANIM_FAST_SIM_EN
  localparam int DIV = 4;
`else
  localparam int DIV = FRAME_DIV;
`endif

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/anim_datapath.sv
// anim_datapath: responder for the animation command interface. Executes
// timed step pauses and coin-sprite travel moves, plotting erase/redraw
// bursts to the VGA adapter one pixel of motion per frame.
//   clock, resetn         - system clock, synchronous active-low reset
//   step, travel          - command codes (0 = none)
//   done_step/done_travel - one-cycle completion pulses
//   busy                  - high whenever not IDLE
//   x, y, colour, plot    - VGA pixel write port
// Build option: ANIM_FAST_SIM_EN (see anim_frame_ticker).
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | waiting for a new step or travel code
// STEP_WAIT  | counting down step*STEP_UNIT frame ticks
// T_ERASE    | 16-pixel burst in BG_COLOUR at current position
// T_MOVE     | move one pixel toward target (x first, then y)
// T_DRAW     | 16-pixel burst in COIN_COLOUR at new position
// T_WAIT     | hold until next frame tick
// DONE       | one-cycle done pulse for the command just served
module anim_datapath
  import anim_pkg::*;
#(
  parameter int         FRAME_DIV   = 833333,
  parameter int         STEP_UNIT   = 30,
  parameter logic [2:0] COIN_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [CODE_W-1:0] step,
  input  logic [CODE_W-1:0] travel,
  output logic              done_step,
  output logic              done_travel,
  output logic              busy,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int TCW = $clog2(7 * STEP_UNIT + 1);

  state_t            state, state_nxt;
  logic              tick;
  logic [CODE_W-1:0] step_srv, travel_srv, target;
  logic [X_W-1:0]    pos_x, x_hold, x_pix, tgt_x;
  logic [Y_W-1:0]    pos_y, y_hold, y_pix, tgt_y;
  logic [2:0]        colour_hold;
  logic [TCW-1:0]    tcnt;
  logic [3:0]        pix;
  logic              is_travel;
  logic              step_new, travel_new, at_target, plotting;

  anim_frame_ticker #(.FRAME_DIV(FRAME_DIV)) u_ticker (
    .clock  (clock),
    .resetn (resetn),
    .tick   (tick)
  );

  assign step_new   = (step != '0) && (step != step_srv);
  assign travel_new = (travel != '0) && (travel != travel_srv);
  assign tgt_x      = node_x(target);
  assign tgt_y      = node_y(target);
  assign at_target  = (pos_x == tgt_x) && (pos_y == tgt_y);
  assign plotting   = (state == ST_T_ERASE) || (state == ST_T_DRAW);
  // Raster order within the sprite: pix[1:0] is dx (inner), pix[3:2] is dy.
  assign x_pix      = pos_x + {6'd0, pix[1:0]};
  assign y_pix      = pos_y + {5'd0, pix[3:2]};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (step_new) begin
          state_nxt = ST_STEP_WAIT;
        end else if (travel_new) begin
          if ((pos_x == node_x(travel)) && (pos_y == node_y(travel))) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_T_ERASE;
          end
        end
      end
      ST_STEP_WAIT: if (tcnt == '0) state_nxt = ST_DONE;
      ST_T_ERASE:   if (pix == 4'd15) state_nxt = ST_T_MOVE;
      ST_T_MOVE:    state_nxt = ST_T_DRAW;
      ST_T_DRAW: begin
        if (pix == 4'd15) state_nxt = at_target ? ST_DONE : ST_T_WAIT;
      end
      ST_T_WAIT:    if (tick) state_nxt = ST_T_ERASE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    plot        = plotting;
    done_step   = (state == ST_DONE) && !is_travel;
    done_travel = (state == ST_DONE) && is_travel;
    x           = plotting ? x_pix : x_hold;
    y           = plotting ? y_pix : y_hold;
    colour      = colour_hold;
    if (state == ST_T_ERASE) colour = BG_COLOUR;
    if (state == ST_T_DRAW)  colour = COIN_COLOUR;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      step_srv    <= '0;
      travel_srv  <= '0;
      target      <= '0;
      pos_x       <= node_x(3'd0);
      pos_y       <= node_y(3'd0);
      tcnt        <= '0;
      pix         <= '0;
      is_travel   <= 1'b0;
      x_hold      <= '0;
      y_hold      <= '0;
      colour_hold <= '0;
    end else begin
      if (step == '0)   step_srv   <= '0;
      if (travel == '0) travel_srv <= '0;
      case (state)
        ST_IDLE: begin
          pix <= '0;
          if (step_new) begin
            step_srv  <= step;
            tcnt      <= TCW'(step * STEP_UNIT);
            is_travel <= 1'b0;
          end else if (travel_new) begin
            travel_srv <= travel;
            target     <= travel;
            is_travel  <= 1'b1;
          end
        end
        ST_STEP_WAIT: begin
          if (tick && (tcnt != '0)) tcnt <= tcnt - 1'b1;
        end
        ST_T_ERASE, ST_T_DRAW: begin
          pix         <= pix + 4'd1;
          x_hold      <= x_pix;
          y_hold      <= y_pix;
          colour_hold <= (state == ST_T_DRAW) ? COIN_COLOUR : BG_COLOUR;
        end
        ST_T_MOVE: begin
          if (pos_x < tgt_x)      pos_x <= pos_x + 1'b1;
          else if (pos_x > tgt_x) pos_x <= pos_x - 1'b1;
          else if (pos_y < tgt_y) pos_y <= pos_y + 1'b1;
          else if (pos_y > tgt_y) pos_y <= pos_y - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anim_datapath.sv
module tb_anim_datapath;

  localparam logic [2:0] COIN = 3'b110;
  localparam logic [2:0] BG   = 3'b000;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] step = 3'd0;
  logic [2:0] travel = 3'd0;
  logic       done_step, done_travel, busy, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;

  // monitor statistics (written only by the monitor process)
  int n_plot = 0, n_bg = 0, n_coin = 0, n_ds = 0, n_dt = 0;
  int n_xinc = 0, n_xdec = 0, n_yinc = 0, n_ydec = 0, n_jump = 0, n_order = 0;
  int bx_min = 0, bx_max = 0, by_min = 0, by_max = 0, burst_coin = 0;
  int org_x = 0, org_y = 0;
  bit have_org = 0, prev_plot = 0, last_was_y = 0;

  anim_datapath #(
    .FRAME_DIV   (4),
    .STEP_UNIT   (2),
    .COIN_COLOUR (COIN),
    .BG_COLOUR   (BG)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .step        (step),
    .travel      (travel),
    .done_step   (done_step),
    .done_travel (done_travel),
    .busy        (busy),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    int dxi, dyi;
    if (plot) begin
      n_plot++;
      if (colour == BG) n_bg++;
      if (colour == COIN) begin
        n_coin++;
        if (!prev_plot) begin
          if (have_org) begin
            dxi = int'(x) - org_x;
            dyi = int'(y) - org_y;
            if (dyi == 0 && (dxi == 1 || dxi == -1)) begin
              if (dxi == 1) n_xinc++; else n_xdec++;
              if (last_was_y) n_order++;
              last_was_y = 0;
            end else if (dxi == 0 && (dyi == 1 || dyi == -1)) begin
              if (dyi == 1) n_yinc++; else n_ydec++;
              last_was_y = 1;
            end else begin
              n_jump++;
            end
          end
          have_org = 1;
          org_x = int'(x);
          org_y = int'(y);
          bx_min = int'(x); bx_max = int'(x);
          by_min = int'(y); by_max = int'(y);
          burst_coin = 0;
        end
        burst_coin++;
        if (int'(x) < bx_min) bx_min = int'(x);
        if (int'(x) > bx_max) bx_max = int'(x);
        if (int'(y) < by_min) by_min = int'(y);
        if (int'(y) > by_max) by_max = int'(y);
      end
    end
    prev_plot = plot;
    if (done_step) n_ds++;
    if (done_travel) begin
      n_dt++;
      last_was_y = 0;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; step = 3'd0; travel = 3'd0;
    cyc(); cyc();
    checks++;
    if ({busy, plot, done_step, done_travel} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {busy, plot, done_step, done_travel});
    end
    checks++;
    if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d want 0 0 0", x, y, colour);
    end
    resetn = 1'b1; travel = 3'd1;
    cyc();
    checks++;
    if (plot !== 1'b1 || x !== 8'd8 || y !== 7'd56 || colour !== BG) begin
      errors++;
      $display("FAIL first_erase: got p=%0d x=%0d y=%0d c=%0d want 1 8 56 0", plot, x, y, colour);
    end
    cyc();
    checks++;
    if (x !== 8'd9 || y !== 7'd56) begin
      errors++;
      $display("FAIL raster_order: got x=%0d y=%0d want 9 56", x, y);
    end
    resetn = 1'b0; travel = 3'd0;
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_step();
    int k, ds0, busy_cnt;
    bit found;
    ds0 = n_ds;
    step = 3'd3;
    found = 0; k = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(); k++;
      if (done_step === 1'b1) found = 1;
    end
    checks++;
    if (!found || k < 23 || k > 26) begin
      errors++;
      $display("FAIL step3_latency: got %0d cycles (found=%0d) want 23..26", k, found);
    end
    cyc();
    checks++;
    if (done_step !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL step3_pulse_width: got ds=%0d busy=%0d want 0 0", done_step, busy);
    end
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 0 || n_ds - ds0 != 1) begin
      errors++;
      $display("FAIL step3_no_repeat: got busy=%0d pulses=%0d want 0 1", busy_cnt, n_ds - ds0);
    end
    step = 3'd1;
    found = 0; k = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc(); k++;
      if (done_step === 1'b1) found = 1;
    end
    checks++;
    if (!found || k < 7 || k > 10) begin
      errors++;
      $display("FAIL step1_latency: got %0d cycles (found=%0d) want 7..10", k, found);
    end
    step = 3'd0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_travel_node1();
    int p0, bg0, c0, dt0;
    bit found;
    resetn = 1'b0; cyc(); resetn = 1'b1; cyc();
    p0 = n_plot; bg0 = n_bg; c0 = n_coin; dt0 = n_dt;
    travel = 3'd1;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      cyc();
      if (done_travel === 1'b1) found = 1;
    end
    checks++;
    if (!found || busy !== 1'b1) begin
      errors++;
      $display("FAIL node1_done: got found=%0d busy=%0d want 1 1", found, busy);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || done_travel !== 1'b0) begin
      errors++;
      $display("FAIL node1_busy_fall: got busy=%0d dt=%0d want 0 0", busy, done_travel);
    end
    for (int i = 0; i < 20; i++) cyc();
    checks++;
    if (n_plot - p0 != 1024 || n_bg - bg0 != 512 || n_coin - c0 != 512) begin
      errors++;
      $display("FAIL node1_plots: got all=%0d bg=%0d coin=%0d want 1024 512 512",
               n_plot - p0, n_bg - bg0, n_coin - c0);
    end
    checks++;
    if (bx_min != 40 || bx_max != 43 || by_min != 56 || by_max != 59 || burst_coin != 16) begin
      errors++;
      $display("FAIL node1_final_box: got x %0d..%0d y %0d..%0d n=%0d want x 40..43 y 56..59 n=16",
               bx_min, bx_max, by_min, by_max, burst_coin);
    end
    checks++;
    if (n_dt - dt0 != 1) begin
      errors++;
      $display("FAIL node1_done_count: got %0d want 1", n_dt - dt0);
    end
  endtask

  task automatic test_travel_node5();
    int xi0, xd0, yi0, yd0, j0, o0, dt0;
    bit found;
    xi0 = n_xinc; xd0 = n_xdec; yi0 = n_yinc; yd0 = n_ydec;
    j0 = n_jump; o0 = n_order; dt0 = n_dt;
    travel = 3'd5;
    found = 0;
    for (int i = 0; i < 8000 && !found; i++) begin
      cyc();
      if (done_travel === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL node5_done: got no done_travel want one within 8000 cycles");
    end
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (n_xinc - xi0 != 96 || n_ydec - yd0 != 32) begin
      errors++;
      $display("FAIL node5_moves: got xinc=%0d ydec=%0d want 96 32", n_xinc - xi0, n_ydec - yd0);
    end
    checks++;
    if (n_xdec - xd0 != 0 || n_yinc - yi0 != 0 || n_jump - j0 != 0 || n_order - o0 != 0) begin
      errors++;
      $display("FAIL node5_monotonic: got xdec=%0d yinc=%0d jump=%0d order=%0d want 0 0 0 0",
               n_xdec - xd0, n_yinc - yi0, n_jump - j0, n_order - o0);
    end
    checks++;
    if (bx_min != 136 || bx_max != 139 || by_min != 24 || by_max != 27 || n_dt - dt0 != 1) begin
      errors++;
      $display("FAIL node5_final: got x %0d..%0d y %0d..%0d done=%0d want x 136..139 y 24..27 done=1",
               bx_min, bx_max, by_min, by_max, n_dt - dt0);
    end
  endtask

  task automatic test_simultaneous();
    int p0, ds0, dt0, k;
    bit found;
    ds0 = n_ds; dt0 = n_dt;
    step = 3'd2; travel = 3'd3;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (done_step === 1'b1) found = 1;
    end
    checks++;
    if (!found || done_travel !== 1'b0 || n_plot != 0 && prev_plot) begin
      errors++;
      $display("FAIL both_step_first: got found=%0d dt=%0d want 1 0", found, done_travel);
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL both_idle_gap: got busy=%0d want 0", busy);
    end
    cyc();
    checks++;
    if (plot !== 1'b1 || x !== 8'd136 || y !== 7'd24 || colour !== BG) begin
      errors++;
      $display("FAIL both_travel_start: got p=%0d x=%0d y=%0d c=%0d want 1 136 24 0", plot, x, y, colour);
    end
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      cyc();
      if (done_travel === 1'b1) found = 1;
    end
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (!found || n_ds - ds0 != 1 || n_dt - dt0 != 1 ||
        bx_min != 104 || bx_max != 107 || by_min != 56 || by_max != 59) begin
      errors++;
      $display("FAIL both_travel_end: got found=%0d ds=%0d dt=%0d x %0d..%0d y %0d..%0d want 1 1 1 x 104..107 y 56..59",
               found, n_ds - ds0, n_dt - dt0, bx_min, bx_max, by_min, by_max);
    end
    travel = 3'd0;
    cyc();
    p0 = n_plot; dt0 = n_dt;
    travel = 3'd3;
    found = 0; k = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(); k++;
      if (done_travel === 1'b1) found = 1;
    end
    checks++;
    if (!found || k != 1) begin
      errors++;
      $display("FAIL same_node_latency: got found=%0d k=%0d want 1 1", found, k);
    end
    for (int i = 0; i < 10; i++) cyc();
    checks++;
    if (n_plot - p0 != 0 || n_dt - dt0 != 1) begin
      errors++;
      $display("FAIL same_node_noplot: got plots=%0d done=%0d want 0 1", n_plot - p0, n_dt - dt0);
    end
    step = 3'd0;
  endtask

  task automatic test_reset_mid();
    int dt0, ds0, busy_cnt;
    bit found;
    travel = 3'd4;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (plot === 1'b1 && colour === COIN) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach_draw: got no draw burst want one within 200 cycles");
    end
    cyc(); cyc();
    dt0 = n_dt; ds0 = n_ds;
    resetn = 1'b0; travel = 3'd0;
    cyc();
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done_travel !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: got p=%0d busy=%0d dt=%0d want 0 0 0", plot, busy, done_travel);
    end
    resetn = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 0 || n_dt - dt0 != 0 || n_ds - ds0 != 0) begin
      errors++;
      $display("FAIL mid_no_done: got busy=%0d dt=%0d ds=%0d want 0 0 0", busy_cnt, n_dt - dt0, n_ds - ds0);
    end
    travel = 3'd1;
    cyc();
    checks++;
    if (plot !== 1'b1 || x !== 8'd8 || y !== 7'd56 || colour !== BG) begin
      errors++;
      $display("FAIL mid_restart_node0: got p=%0d x=%0d y=%0d c=%0d want 1 8 56 0", plot, x, y, colour);
    end
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      cyc();
      if (done_travel === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_restart_done: got no done_travel want one within 3000 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_travel_node1();
    test_travel_node5();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anim_datapath.md
Name: anim_datapath

Overview:
- Responder end of the animation command interface. The animations controller issues `step` and `travel` codes; this block executes them and returns `done_step` / `done_travel`.
- `step` commands are timed processing pauses.
- `travel` commands move a 4x4 coin sprite across the VGA framebuffer between fixed waypoints. Each move is an erase/redraw at one pixel per frame.
- Sits between the animations controller and the VGA adapter.

Parameters:
- FRAME_DIV, 833333, clock cycles per frame tick (60 Hz at 50 MHz).
- STEP_UNIT, 30, frame ticks per unit of step code.
- COIN_COLOUR, 3'b110, sprite colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clock  input  1  system clock (CLOCK_50 domain)
- resetn  input  1  synchronous active-low reset
- step  input  3  step command; 0 = none, 1..7 = pause of step*STEP_UNIT ticks
- travel  input  3  travel command; 0 = none, k = move coin to node k
- done_step  output  1  one-cycle pulse when a step completes
- done_travel  output  1  one-cycle pulse when a travel completes
- busy  output  1  a command is executing
- x  output  8  pixel x
- y  output  7  pixel y
- colour  output  3  pixel colour
- plot  output  1  pixel write strobe

Behaviour:
- Reset (resetn low at a clock edge): all outputs 0; state IDLE; coin position = node0; frame counter 0; served-code latches 0. The screen is not cleared.
- Frame tick: free-running counter, 0..FRAME_DIV-1. Tick is a one-cycle strobe at wrap.
- Command acceptance:
  - A code is new when it is nonzero and differs from its served latch.
  - An input of 0 clears its latch.
  - Evaluated only in IDLE.
  - If step and travel are both new in the same cycle, step is served first; travel is accepted on return to IDLE.
- States: IDLE, STEP_WAIT, T_ERASE, T_MOVE, T_DRAW, T_WAIT, DONE.
- IDLE -> STEP_WAIT on new step:
  - Latch code; load tick counter with step*STEP_UNIT.
  - Decrement on each tick; at 0 go to DONE.
  - DONE pulses done_step for 1 cycle, then returns to IDLE.
- IDLE -> T_ERASE on new travel k:
  - Latch code and target node k.
  - If position already equals the target: DONE next cycle, pulse done_travel, no plotting.
- T_ERASE: 16 consecutive cycles with plot=1, colour=BG_COLOUR, raster order (dx 0..3 inner, dy 0..3 outer), at (pos_x+dx, pos_y+dy).
- T_MOVE (1 cycle):
  - Step one pixel toward the target: x first until equal, then y.
  - Width: x 8-bit, y 7-bit, unsigned; never overshoots.
- T_DRAW: 16 cycles as T_ERASE, with colour=COIN_COLOUR.
  - If position == target: go to DONE and pulse done_travel.
  - Otherwise go to T_WAIT.
- T_WAIT: waits for the next tick, then goes to T_ERASE.
- busy = 1 in every state except IDLE.
- plot = 1 only in T_ERASE/T_DRAW; x/y/colour hold their last value otherwise.
- Command inputs changing mid-execution are ignored until IDLE.
- Reset mid-operation aborts immediately; no done pulse is produced.

Optional Feature:
- ANIM_FAST_SIM_EN defined: frame divider is forced to 4 cycles regardless of FRAME_DIV.
- Without it: FRAME_DIV is used.
- All other behaviour is identical in both cases.

Decomposition:
- Package anim_pkg:
  - node coordinate constants: node0 (8,56), node1 (40,56), node2 (72,56), node3 (104,56), node4 (136,56), node5 (136,24), node6 (72,24), node7 (8,24);
  - sprite size 4;
  - state encoding localparams;
  - step/travel code width 3.
- One sub-module: anim_frame_ticker (frame counter plus tick strobe; owns the ANIM_FAST_SIM_EN switch).

Test Plan:
All scenarios run with ANIM_FAST_SIM_EN and STEP_UNIT=2.
1. Reset for 2 cycles -> all outputs 0; then travel=1 starts erasing at (8,56).
2. step=3 held -> exactly one done_step, after 6 ticks (~24 cycles). Holding 3 produces no repeat. Changing to 1 -> second pulse after 2 ticks.
3. From reset, travel=1 -> 32 moves, 1024 plot strobes. Final draw covers x 40..43, y 56..59 in COIN_COLOUR. One done_travel; busy falls the cycle after.
4. From node1, travel=5 -> 96 x-increments then 32 y-decrements, x/y monotonic. done_travel once position reaches (136,24).
5. step=2 and travel=3 asserted in the same IDLE cycle -> done_step first; travel starts on the next IDLE cycle. travel=current node -> done_travel with zero plot strobes.
6. resetn low for 1 cycle mid T_DRAW -> plot/busy 0 the next cycle, no done pulse. Subsequent travel=1 begins erasing at node0.
